mcu_sched: RTL and testbench
============================

MCU_SCHED -- requirements
Module: mcu_sched

Interface
REQ-001 SHALL have parameter W_PW, 12, picture width bits.
REQ-002 SHALL have parameter W_PH, 12, picture height bits.
REQ-003 SHALL have parameter NUM_ROWBUF, 2, number of MCU-row buffers in the camera buffer (>=1).
REQ-004 SHALL have parameter EE_SLOTS, 8, number of entropy-encoder buffer slots (power of two, >=2).
REQ-005 SHALL have ports, with clock and reset first; one clock; reset asynchronous, active-high:
 clk  in  1  sole clock
 rst  in  1  asynchronous active-high reset
 frame_start_i  in  1  pulse: new picture, samples geometry and mode
 pic_width_i  in  W_PW  pixels
 pic_height_i  in  W_PH  lines
 mode_i  in  2  0=444 (8x8 MCU), 1=422 (16x8), 2=420 (16x16), 3=treated as 444
 row_ready_i  in  1  pulse: one MCU row written by camera
 done_i  in  1  pulse: fdct finished current MCU
 slot_free_i  in  1  pulse: entropy encoder released one slot
 go_o  out  1  pulse: start fdct on MCU
 mcu_col_o  out  W_PW-3  MCU column
 mcu_row_o  out  W_PH-3  MCU row
 rowbuf_id_o  out  clog2(NUM_ROWBUF)  row buffer holding MCU
 last_in_row_o / last_in_pic_o  out  1 each  qualifiers valid with go_o
 row_release_o  out  1  pulse: row buffer free for camera
 frame_done_o  out  1  pulse: last MCU of picture done
 busy_o  out  1  state != IDLE
 err_too_fast_o / err_credit_o  out  1 each  sticky error flags

Function
REQ-006 SHALL implement states IDLE, ARMED, BUSY; IDLE->ARMED on frame_start_i; ARMED->BUSY on go_o; BUSY->ARMED on done_i; BUSY->IDLE on done_i when current MCU is last_in_pic.
REQ-007 SHALL compute at frame_start_i: mcus_w = (w+7)>>3 for modes 0/3, (w+15)>>4 for modes 1/2; mcus_h = (h+15)>>4 for mode 2, else (h+7)>>3; held constant until next frame_start_i.
REQ-008 SHALL keep rows_avail (0..NUM_ROWBUF): +1 on row_ready_i, -1 on row_release_o, unchanged when both in one cycle.
REQ-009 SHALL set err_too_fast_o when row_ready_i arrives with rows_avail==NUM_ROWBUF and no same-cycle release; rows_avail saturates.
REQ-010 SHALL keep ee_used (0..EE_SLOTS): +1 on go_o, -1 on slot_free_i, unchanged when both together; slot_free_i at 0 sets err_credit_o and leaves 0.
REQ-011 SHALL, in ARMED with rows_avail!=0 and ee_used<EE_SLOTS in cycle N, assert go_o for exactly one cycle in N+1 with coordinates and qualifiers registered and stable until next go_o.
REQ-012 SHALL advance column on done_i in BUSY; at last column wrap column to 0, increment row, pulse row_release_o same cycle as the advance, advance rowbuf_id modulo NUM_ROWBUF.
REQ-013 SHALL pulse frame_done_o with the done_i of the last_in_pic MCU (together with row_release_o).
REQ-014 SHALL give minimum done_i-to-next-go_o latency of 2 cycles.
REQ-015 SHALL ignore done_i outside BUSY and row_ready_i in IDLE.
REQ-016 SHALL, on frame_start_i in any state, abort: col/row/rowbuf_id=0, rows_avail=0, errors cleared, state ARMED; ee_used preserved; frame_start_i overrides simultaneous done_i/row_ready_i.

Reset
REQ-017 SHALL on rst: state IDLE, all counters 0, mcus_w/mcus_h 0, every output 0.

Configuration
REQ-018 SHALL, with MCU_SCHED_STATS_EN defined, add outputs stall_cycles_o (16 bits, saturating, counts ARMED cycles with rows_avail!=0 and ee_used==EE_SLOTS) and mcu_count_o (W_PW+W_PH-6 bits, MCUs dispatched), both cleared on frame_start_i and rst.
REQ-019 SHALL, without MCU_SCHED_STATS_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-020 SHALL place mode encoding, state encoding, MCU size constants in package mcu_sched_pkg.
REQ-021 SHALL use one sub-module, sat_updown_cnt (saturating up/down counter with error-on-overflow/underflow), instantiated for rows_avail and ee_used.

Verification
REQ-022 444, 32x16, 2 rows delivered, done_i 3 cycles after each go -> 8 go_o, coords (0,0)..(3,1), last_in_row at col 3, frame_done_o once, 2 row_release_o.
REQ-023 420, 40x20 -> mcus_w=3, mcus_h=2; 6 MCUs dispatched, last_in_pic at (2,1).
REQ-024 EE_SLOTS=8, no slot_free_i -> exactly 8 go_o then stall; one slot_free_i -> one more go_o 2 cycles later; stall_cycles_o counts when enabled.
REQ-025 NUM_ROWBUF=2, three row_ready_i before any release -> err_too_fast_o=1, rows_avail=2; simultaneous row_ready_i and release -> no error.
REQ-026 frame_start_i mid-BUSY -> next go_o at (0,0), errors cleared, ee_used unchanged; slot_free_i at ee_used=0 -> err_credit_o=1.

Source files
------------

// File: rtl/mcu_sched_pkg.sv
// Shared encodings for the MCU scheduler: chroma modes, FSM states, MCU sizes
// and the picture-to-MCU-grid helper.
package mcu_sched_pkg;

  typedef enum logic [1:0] {
    MODE_444     = 2'd0,
    MODE_422     = 2'd1,
    MODE_420     = 2'd2,
    MODE_444_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam int unsigned MCU_BLK_LOG2 = 3;  // 8-pixel MCU edge
  localparam int unsigned MCU_DBL_LOG2 = 4;  // 16-pixel MCU edge

  // Number of MCUs needed to cover pix samples, rounding partial MCUs up.
  function automatic int unsigned mcu_span(input int unsigned pix, input logic dbl);
    if (dbl) return (pix + (32'd1 << MCU_DBL_LOG2) - 32'd1) >> MCU_DBL_LOG2;
    return (pix + (32'd1 << MCU_BLK_LOG2) - 32'd1) >> MCU_BLK_LOG2;
  endfunction

endpackage

// File: rtl/mcu_sched_sat_updown_cnt.sv
// Saturating up/down counter in 0..MAX; err flags an increment at MAX or a
// decrement at 0 (the count is left unchanged in both cases).
module sat_updown_cnt #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  logic full, empty;

  assign full  = (cnt == W'(MAX));
  assign empty = (cnt == '0);
  assign err   = ~clr & ((inc & ~dec & full) | (dec & ~inc & empty));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc & ~dec & ~full)    cnt <= cnt + W'(1);
    else if (dec & ~inc & ~empty)   cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/mcu_sched.sv
// MCU dispatcher between camera row buffers, the fdct and the entropy encoder.
// Define MCU_SCHED_STATS_EN to add stall_cycles_o / mcu_count_o statistics.
module mcu_sched
  import mcu_sched_pkg::*;
#(
  parameter int W_PW       = 12,
  parameter int W_PH       = 12,
  parameter int NUM_ROWBUF = 2,
  parameter int EE_SLOTS   = 8,
  localparam int RBW       = (NUM_ROWBUF > 1) ? $clog2(NUM_ROWBUF) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_i,
  input  logic [W_PW-1:0]   pic_width_i,
  input  logic [W_PH-1:0]   pic_height_i,
  input  logic [1:0]        mode_i,
  input  logic              row_ready_i,
  input  logic              done_i,
  input  logic              slot_free_i,
  output logic              go_o,
  output logic [W_PW-4:0]   mcu_col_o,
  output logic [W_PH-4:0]   mcu_row_o,
  output logic [RBW-1:0]    rowbuf_id_o,
  output logic              last_in_row_o,
  output logic              last_in_pic_o,
  output logic              row_release_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              err_too_fast_o,
  output logic              err_credit_o
`ifdef MCU_SCHED_STATS_EN
  ,
  output logic [15:0]       stall_cycles_o,
  output logic [W_PW+W_PH-7:0] mcu_count_o
`endif
);

  localparam int CW = W_PW - 3;
  localparam int RW = W_PH - 3;
  localparam int MW = W_PW - 2;
  localparam int HW = W_PH - 2;
  localparam int AW = $clog2(NUM_ROWBUF + 1);
  localparam int EW = $clog2(EE_SLOTS + 1);

  state_e         state;
  logic [MW-1:0]  mcus_w;
  logic [HW-1:0]  mcus_h;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [RBW-1:0] rb_id;
  logic [AW-1:0]  rows_avail;
  logic [EW-1:0]  ee_used;
  logic           rows_err, ee_err;
  logic           last_col, last_row, rows_ok, can_go, ready_inc, dbl_w, dbl_h;
  mode_e          mode;

  assign mode     = mode_e'(mode_i);
  assign dbl_w    = (mode == MODE_422) || (mode == MODE_420);
  assign dbl_h    = (mode == MODE_420);
  assign last_col = (MW'(col) == mcus_w - MW'(1));
  assign last_row = (HW'(row) == mcus_h - HW'(1));
  assign busy_o   = (state != ST_IDLE);

  // A release pulse still counts in rows_avail this cycle; don't dispatch
  // into the row that was just handed back to the camera.
  assign rows_ok   = row_release_o ? (rows_avail > AW'(1)) : (rows_avail != '0);
  assign can_go    = (state == ST_ARMED) & rows_ok & (ee_used < EW'(EE_SLOTS)) & ~frame_start_i;
  assign ready_inc = row_ready_i & (state != ST_IDLE) & ~frame_start_i;

  sat_updown_cnt #(.MAX(NUM_ROWBUF)) u_rows (
    .clk(clk), .rst(rst), .clr(frame_start_i),
    .inc(ready_inc), .dec(row_release_o),
    .cnt(rows_avail), .err(rows_err)
  );

  sat_updown_cnt #(.MAX(EE_SLOTS)) u_ee (
    .clk(clk), .rst(rst), .clr(1'b0),
    .inc(go_o), .dec(slot_free_i),
    .cnt(ee_used), .err(ee_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mcus_w         <= '0;
      mcus_h         <= '0;
      col            <= '0;
      row            <= '0;
      rb_id          <= '0;
      go_o           <= 1'b0;
      mcu_col_o      <= '0;
      mcu_row_o      <= '0;
      rowbuf_id_o    <= '0;
      last_in_row_o  <= 1'b0;
      last_in_pic_o  <= 1'b0;
      row_release_o  <= 1'b0;
      frame_done_o   <= 1'b0;
      err_too_fast_o <= 1'b0;
      err_credit_o   <= 1'b0;
    end else begin
      go_o          <= 1'b0;
      row_release_o <= 1'b0;
      frame_done_o  <= 1'b0;
      if (rows_err) err_too_fast_o <= 1'b1;
      if (ee_err)   err_credit_o   <= 1'b1;
      if (frame_start_i) begin
        mcus_w         <= MW'(mcu_span(32'(pic_width_i), dbl_w));
        mcus_h         <= HW'(mcu_span(32'(pic_height_i), dbl_h));
        col            <= '0;
        row            <= '0;
        rb_id          <= '0;
        err_too_fast_o <= 1'b0;
        err_credit_o   <= 1'b0;
        state          <= ST_ARMED;
      end else begin
        case (state)
          ST_ARMED: if (can_go) begin
            go_o          <= 1'b1;
            mcu_col_o     <= col;
            mcu_row_o     <= row;
            rowbuf_id_o   <= rb_id;
            last_in_row_o <= last_col;
            last_in_pic_o <= last_col & last_row;
            state         <= ST_BUSY;
          end
          ST_BUSY: if (done_i) begin
            if (last_col) begin
              col           <= '0;
              row           <= row + RW'(1);
              rb_id         <= (rb_id == RBW'(NUM_ROWBUF - 1)) ? '0 : rb_id + RBW'(1);
              row_release_o <= 1'b1;
            end else begin
              col <= col + CW'(1);
            end
            if (last_col & last_row) begin
              frame_done_o <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              state <= ST_ARMED;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MCU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o <= '0;
      mcu_count_o    <= '0;
    end else if (frame_start_i) begin
      stall_cycles_o <= '0;
      mcu_count_o    <= '0;
    end else begin
      if ((state == ST_ARMED) && (rows_avail != '0) && (ee_used == EW'(EE_SLOTS)) &&
          (stall_cycles_o != 16'hFFFF))
        stall_cycles_o <= stall_cycles_o + 16'd1;
      if (go_o) mcu_count_o <= mcu_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mcu_sched.sv
// Self-checking bench for mcu_sched: directed corner steps plus random frames
// checked against a grid-level model of the expected MCU sequence.
module tb_mcu_sched;

  localparam int NRB = 2;
  localparam int EES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start_i = 1'b0;
  logic [11:0] pic_width_i = '0;
  logic [11:0] pic_height_i = '0;
  logic [1:0]  mode_i = '0;
  logic        row_ready_i = 1'b0;
  logic        done_i = 1'b0;
  logic        slot_free_i = 1'b0;
  logic        go_o, last_in_row_o, last_in_pic_o, row_release_o, frame_done_o;
  logic        busy_o, err_too_fast_o, err_credit_o;
  logic [8:0]  mcu_col_o, mcu_row_o;
  logic [0:0]  rowbuf_id_o;
`ifdef MCU_SCHED_STATS_EN
  logic [15:0] stall_cycles_o;
  logic [17:0] mcu_count_o;
`endif

  mcu_sched #(.W_PW(12), .W_PH(12), .NUM_ROWBUF(NRB), .EE_SLOTS(EES)) dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start_i),
    .pic_width_i(pic_width_i), .pic_height_i(pic_height_i), .mode_i(mode_i),
    .row_ready_i(row_ready_i), .done_i(done_i), .slot_free_i(slot_free_i),
    .go_o(go_o), .mcu_col_o(mcu_col_o), .mcu_row_o(mcu_row_o),
    .rowbuf_id_o(rowbuf_id_o), .last_in_row_o(last_in_row_o),
    .last_in_pic_o(last_in_pic_o), .row_release_o(row_release_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o),
    .err_too_fast_o(err_too_fast_o), .err_credit_o(err_credit_o)
`ifdef MCU_SCHED_STATS_EN
    , .stall_cycles_o(stall_cycles_o), .mcu_count_o(mcu_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ee = 0;     // model of occupied entropy-encoder slots
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle: inputs set after this call apply to the new cycle.
  task automatic step();
    @(posedge clk);
    if (slot_free_i && ee > 0) ee--;
    #1;
    frame_start_i = 1'b0; row_ready_i = 1'b0; done_i = 1'b0; slot_free_i = 1'b0;
    cyc++;
    if (go_o) begin
      chk("ee_room", 32'(ee < EES), 1);
      ee++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && ee > 0; t++) begin
      slot_free_i = 1'b1;
      step();
    end
  endtask

  task automatic start(input int w, input int h, input int m);
    frame_start_i = 1'b1;
    pic_width_i   = 12'(w);
    pic_height_i  = 12'(h);
    mode_i        = 2'(m);
  endtask

  // Full frame with randomized camera, fdct and encoder timing.
  task automatic run_frame(input int w, input int h, input int m, input int dfix);
    int mw, mh, k, sent, rel, fd, cd, last_done;
    mw = (m == 1 || m == 2) ? (w + 15) / 16 : (w + 7) / 8;
    mh = (m == 2) ? (h + 15) / 16 : (h + 7) / 8;
    k = 0; sent = 0; rel = 0; fd = 0; cd = 0; last_done = -100;
    step();
    start(w, h, m);
    for (int t = 0; t < 3000 && fd == 0; t++) begin
      step();
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin done_i = 1'b1; last_done = cyc; end
      end
      if (go_o) begin
        chk("go_col", 32'(mcu_col_o), 32'(k % mw));
        chk("go_row", 32'(mcu_row_o), 32'(k / mw));
        chk("go_rowbuf", 32'(rowbuf_id_o), 32'((k / mw) % NRB));
        chk("go_last_in_row", 32'(last_in_row_o), 32'((k % mw) == mw - 1));
        chk("go_last_in_pic", 32'(last_in_pic_o), 32'(k == mw * mh - 1));
        chk("go_row_delivered", 32'((k / mw) < sent), 1);
        chk("go_latency", 32'(cyc - last_done >= 2), 1);
        k++;
        cd = (dfix != 0) ? dfix : int'($urandom_range(1, 4));
      end
      if (row_release_o) rel++;
      if (frame_done_o) begin
        fd = 1;
        chk("frame_done_with_release", 32'(row_release_o), 1);
      end
      if (sent < mh && sent - rel < NRB && $urandom_range(0, 2) == 0) begin
        row_ready_i = 1'b1; sent++;
      end
      if (ee > 0 && $urandom_range(0, 1) == 0) slot_free_i = 1'b1;
    end
    chk("frame_done_seen", 32'(fd), 1);
    chk("mcu_total", 32'(k), 32'(mw * mh));
    chk("row_releases", 32'(rel), 32'(mh));
    chk("frame_err_too_fast", 32'(err_too_fast_o), 0);
    chk("frame_err_credit", 32'(err_credit_o), 0);
    step();
    chk("idle_after_frame", 32'(busy_o), 0);
    chk("frame_done_single", 32'(frame_done_o), 0);
  endtask

  initial begin
    int ngo, cd, t;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_go", 32'(go_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_col", 32'(mcu_col_o), 0);
    chk("rst_row", 32'(mcu_row_o), 0);
    chk("rst_rowbuf", 32'(rowbuf_id_o), 0);
    chk("rst_last", 32'({last_in_row_o, last_in_pic_o}), 0);
    chk("rst_pulses", 32'({row_release_o, frame_done_o}), 0);
    chk("rst_errs", 32'({err_too_fast_o, err_credit_o}), 0);
`ifdef MCU_SCHED_STATS_EN
    chk("rst_stats", 32'(stall_cycles_o) + 32'(mcu_count_o), 0);
`endif
    rst = 1'b0;

    // Credit underflow with nothing outstanding
    step();
    slot_free_i = 1'b1;
    step();
    step();
    chk("err_credit_set", 32'(err_credit_o), 1);

    // 444 32x16 with fixed 3-cycle fdct, then 420 40x20
    run_frame(32, 16, 0, 3);
    run_frame(40, 20, 2, 0);

    // Encoder credit stall: 16-MCU frame, no slot returns
    drain();
    step(); start(64, 16, 0);
    step(); row_ready_i = 1'b1;
    step(); row_ready_i = 1'b1;
    ngo = 0; cd = 0;
    repeat (40) begin
      step();
      if (cd > 0) begin cd--; if (cd == 0) done_i = 1'b1; end
      if (go_o) begin ngo++; cd = 1; end
    end
    chk("stall_go_count", 32'(ngo), 8);
`ifdef MCU_SCHED_STATS_EN
    chk("stall_cycles_counted", 32'(stall_cycles_o >= 16'd10), 1);
`endif
    slot_free_i = 1'b1;
    step();
    chk("free_go_plus1", 32'(go_o), 0);
    step();
    chk("free_go_plus2", 32'(go_o), 1);
    chk("free_go_col", 32'(mcu_col_o), 0);
    chk("free_go_row", 32'(mcu_row_o), 1);
    chk("free_go_rowbuf", 32'(rowbuf_id_o), 1);
    step();
`ifdef MCU_SCHED_STATS_EN
    chk("mcu_count", 32'(mcu_count_o), 9);
`endif

    // Abort mid-BUSY: errors clear, encoder occupancy survives
    row_ready_i = 1'b1; step();
    row_ready_i = 1'b1; step();
    chk("busy_too_fast", 32'(err_too_fast_o), 1);
    start(64, 16, 0); done_i = 1'b1;
    step();
    chk("abort_err_clr", 32'(err_too_fast_o), 0);
    chk("abort_busy", 32'(busy_o), 1);
    row_ready_i = 1'b1;
    ngo = 0;
    repeat (10) begin step(); ngo += int'(go_o); end
    chk("abort_ee_kept", 32'(ngo), 0);
    slot_free_i = 1'b1;
    step(); step();
    chk("abort_go", 32'(go_o), 1);
    chk("abort_go_col", 32'(mcu_col_o), 0);
    chk("abort_go_row", 32'(mcu_row_o), 0);

    // Row-buffer overflow, then ready coinciding with a release
    drain();
    step(); start(8, 24, 0);
    step(); row_ready_i = 1'b1;
    step(); row_ready_i = 1'b1;
    step(); row_ready_i = 1'b1;
    step();
    chk("too_fast_third_row", 32'(err_too_fast_o), 1);
    start(8, 24, 0);
    step();
    chk("too_fast_cleared", 32'(err_too_fast_o), 0);
    row_ready_i = 1'b1; step();
    row_ready_i = 1'b1;
    t = 0;
    do begin step(); t++; end while (!go_o && t < 20);
    chk("rb_go_seen", 32'(go_o), 1);
    chk("rb_go_coord", 32'({mcu_col_o, mcu_row_o}), 0);
    done_i = 1'b1;
    step();
    chk("rb_release", 32'(row_release_o), 1);
    row_ready_i = 1'b1;
    step();
    chk("rb_simul_no_err", 32'(err_too_fast_o), 0);
    row_ready_i = 1'b1;
    step();
    chk("rb_saturated_err", 32'(err_too_fast_o), 1);

    // Random geometry and modes
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(1, 100)), int'($urandom_range(1, 60)),
                int'($urandom_range(0, 3)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
